// File: rtl/ledarray_frame_ctrl.sv
// LED-array frame sequencer: streams a command/address/data/control byte frame to a byte writer.
// Optional auto-refresh timer is enabled by defining LEDARRAY_AUTO_REFRESH_EN.
//
// state    | meaning
// IDLE     | no frame in progress, waiting for a request or refresh tick
// CMD_MODE | send 0x40 (start+stop)
// ADDR     | send 0xC0 (start), column counter cleared on entry
// DATA     | send frame-buffer columns 0..NUM_COLS-1, stop on the last
// CTRL     | send display control byte (start+stop)
// DONE     | pulse frame_done, restart if a request is pending
module ledarray_frame_ctrl #(
    parameter int CLK_HZ     = 12_000_000,
    parameter int REFRESH_HZ = 50,
    parameter int NUM_COLS   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fb_we,
    input  logic [3:0] fb_addr,
    input  logic [7:0] fb_data,
    input  logic [2:0] brightness,
    input  logic       display_on,
    input  logic       refresh_req,
    output logic       wr_valid,
    output logic [7:0] wr_value,
    output logic       wr_start,
    output logic       wr_stop,
    input  logic       wr_busy,
    output logic       frame_busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD_MODE,
        S_ADDR,
        S_DATA,
        S_CTRL,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        B_ISSUE,
        B_WAIT_HI,
        B_WAIT_LO
    } phase_t;

    localparam logic [4:0] LP_NCOLS = 5'(NUM_COLS);
    localparam logic [3:0] LP_LAST  = 4'(NUM_COLS - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    phase_t     r_phase;
    phase_t     w_phase_nxt;

    logic [7:0] r_fb [NUM_COLS];
    logic [3:0] r_col;
    logic       r_pending;
    logic [2:0] r_bri;
    logic       r_on;

    logic       r_wr_valid;
    logic [7:0] r_wr_value;
    logic       r_wr_start;
    logic       r_wr_stop;

    logic       w_tick;
    logic       w_req;
    logic       w_byte_state;
    logic       w_issue;
    logic       w_byte_done;
    logic       w_last_col;
    logic       w_start_frame;
    logic [7:0] w_byte;
    logic       w_byte_start;
    logic       w_byte_stop;

`ifdef LEDARRAY_AUTO_REFRESH_EN
    localparam int LP_DIV = (CLK_HZ / REFRESH_HZ > 1) ? CLK_HZ / REFRESH_HZ : 2;
    localparam int LP_CW  = $clog2(LP_DIV);

    logic [LP_CW-1:0] r_tick_cnt;

    // Down-counter reloads on terminal count, so a tick fires once every LP_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= LP_CW'(LP_DIV - 1);
        end else if (r_tick_cnt == '0) begin
            r_tick_cnt <= LP_CW'(LP_DIV - 1);
        end else begin
            r_tick_cnt <= r_tick_cnt - 1'b1;
        end
    end

    assign w_tick = (r_tick_cnt == '0);
`else
    assign w_tick = 1'b0;
`endif

    assign w_req        = refresh_req | w_tick;
    assign w_byte_state = (r_state == S_CMD_MODE) || (r_state == S_ADDR) ||
                          (r_state == S_DATA) || (r_state == S_CTRL);
    assign w_issue      = w_byte_state && (r_phase == B_ISSUE) && !wr_busy;
    assign w_byte_done  = w_byte_state && (r_phase == B_WAIT_LO) && !wr_busy;
    assign w_last_col   = (r_col == LP_LAST);

    always_comb begin
        w_state_nxt  = r_state;
        w_phase_nxt  = r_phase;
        w_byte       = 8'h00;
        w_byte_start = 1'b0;
        w_byte_stop  = 1'b0;

        if (w_byte_state) begin
            unique case (r_phase)
                B_ISSUE:   if (!wr_busy) w_phase_nxt = B_WAIT_HI;
                B_WAIT_HI: if (wr_busy)  w_phase_nxt = B_WAIT_LO;
                B_WAIT_LO: if (!wr_busy) w_phase_nxt = B_ISSUE;
                default:   w_phase_nxt = B_ISSUE;
            endcase
        end else begin
            w_phase_nxt = B_ISSUE;
        end

        unique case (r_state)
            S_IDLE: begin
                if (w_req) w_state_nxt = S_CMD_MODE;
            end
            S_CMD_MODE: begin
                w_byte       = 8'h40;
                w_byte_start = 1'b1;
                w_byte_stop  = 1'b1;
                if (w_byte_done) w_state_nxt = S_ADDR;
            end
            S_ADDR: begin
                w_byte       = 8'hC0;
                w_byte_start = 1'b1;
                if (w_byte_done) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                w_byte      = r_fb[r_col];
                w_byte_stop = w_last_col;
                if (w_byte_done && w_last_col) w_state_nxt = S_CTRL;
            end
            S_CTRL: begin
                w_byte       = r_on ? {5'b10001, r_bri} : 8'h80;
                w_byte_start = 1'b1;
                w_byte_stop  = 1'b1;
                if (w_byte_done) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = (r_pending || w_req) ? S_CMD_MODE : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_start_frame = (w_state_nxt == S_CMD_MODE) &&
                           ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_phase <= B_ISSUE;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    // Requests arriving mid-frame collapse into one pending restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
            r_bri     <= 3'd0;
            r_on      <= 1'b0;
            r_col     <= 4'd0;
        end else begin
            if (w_start_frame) begin
                r_pending <= 1'b0;
                r_bri     <= brightness;
                r_on      <= display_on;
            end else if (w_req && (r_state != S_IDLE)) begin
                r_pending <= 1'b1;
            end

            if ((w_state_nxt == S_ADDR) && (r_state != S_ADDR)) begin
                r_col <= 4'd0;
            end else if ((r_state == S_DATA) && w_byte_done) begin
                r_col <= r_col + 4'd1;
            end
        end
    end

    // Byte fields are captured at issue and held until the next issue; a same-edge
    // host write is not visible to this capture, so the old column value goes out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_valid <= 1'b0;
            r_wr_value <= 8'h00;
            r_wr_start <= 1'b0;
            r_wr_stop  <= 1'b0;
        end else begin
            r_wr_valid <= w_issue;
            if (w_issue) begin
                r_wr_value <= w_byte;
                r_wr_start <= w_byte_start;
                r_wr_stop  <= w_byte_stop;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_COLS; i++) begin
                r_fb[i] <= 8'h00;
            end
        end else if (fb_we && ({1'b0, fb_addr} < LP_NCOLS)) begin
            r_fb[fb_addr] <= fb_data;
        end
    end

    assign wr_valid   = r_wr_valid;
    assign wr_value   = r_wr_value;
    assign wr_start   = r_wr_start;
    assign wr_stop    = r_wr_stop;
    assign frame_busy = (r_state != S_IDLE);
    assign frame_done = (r_state == S_DONE);

endmodule

// File: tb/tb_ledarray_frame_ctrl.sv
// Self-checking bench for ledarray_frame_ctrl: writer model, frame-level reference model, scenario tasks.
module tb_ledarray_frame_ctrl;

    localparam int NCOL = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fb_we;
    logic [3:0] fb_addr;
    logic [7:0] fb_data;
    logic [2:0] brightness;
    logic       display_on;
    logic       refresh_req;
    logic       wr_valid;
    logic [7:0] wr_value;
    logic       wr_start;
    logic       wr_stop;
    logic       wr_busy;
    logic       frame_busy;
    logic       frame_done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int idle_cnt = 0;
    int busy_len = 24;
    logic [9:0] cap_q[$];
    logic [9:0] exp_q[$];
    logic [7:0] mdl_fb[NCOL];

    always #5 clk = ~clk;

    ledarray_frame_ctrl #(
        .CLK_HZ    (1000),
        .REFRESH_HZ(100),
        .NUM_COLS  (NCOL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .brightness (brightness),
        .display_on (display_on),
        .refresh_req(refresh_req),
        .wr_valid   (wr_valid),
        .wr_value   (wr_value),
        .wr_start   (wr_start),
        .wr_stop    (wr_stop),
        .wr_busy    (wr_busy),
        .frame_busy (frame_busy),
        .frame_done (frame_done)
    );

    // Monitor: record issued bytes as {start, stop, value}, count done pulses and idle cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (wr_valid === 1'b1) cap_q.push_back({wr_start, wr_stop, wr_value});
            if (frame_done === 1'b1) done_cnt++;
            if (frame_busy !== 1'b1) idle_cnt++;
        end
    end

    // Byte writer: busy for busy_len cycles per byte; fields must stay put meanwhile.
    initial begin : writer
        logic [9:0] held;
        bit         stable;
        bit         hit_rst;
        wr_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (wr_valid === 1'b1) begin
                held    = {wr_start, wr_stop, wr_value};
                stable  = 1'b1;
                hit_rst = 1'b0;
                wr_busy = 1'b1;
                for (int i = 0; i < busy_len; i++) begin
                    @(negedge clk);
                    if (!rst_n) hit_rst = 1'b1;
                    else if ({wr_start, wr_stop, wr_value} !== held) stable = 1'b0;
                end
                wr_busy = 1'b0;
                if (!hit_rst) begin
                    checks++;
                    if (!stable) begin
                        errors++;
                        $display("FAIL hold_stable: fields changed while busy, issued %h now %h",
                                 held, {wr_start, wr_stop, wr_value});
                    end
                end
            end
        end
    end

    // Reference frame from the byte-level rules: cmd, addr, columns, control.
    task automatic model_frame(input bit on, input logic [2:0] bri);
        exp_q.push_back({1'b1, 1'b1, 8'h40});
        exp_q.push_back({1'b1, 1'b0, 8'hC0});
        for (int c = 0; c < NCOL; c++) exp_q.push_back({1'b0, (c == NCOL - 1), mdl_fb[c]});
        exp_q.push_back({1'b1, 1'b1, on ? {5'b10001, bri} : 8'h80});
    endtask

    task automatic send_req();
        @(negedge clk);
        refresh_req = 1'b1;
        @(negedge clk);
        refresh_req = 1'b0;
    endtask

    task automatic fb_write(input int a, input logic [7:0] d);
        @(negedge clk);
        fb_we   = 1'b1;
        fb_addr = 4'(a);
        fb_data = d;
        @(negedge clk);
        fb_we = 1'b0;
        if (a < NCOL) mdl_fb[a] = d;
    endtask

    task automatic wait_frames(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_bytes(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cap_q.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic new_run();
        cap_q.delete();
        exp_q.delete();
        done_cnt = 0;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        fb_we       = 1'b0;
        fb_addr     = 4'd0;
        fb_data     = 8'd0;
        brightness  = 3'd0;
        display_on  = 1'b0;
        refresh_req = 1'b0;
        for (int c = 0; c < NCOL; c++) mdl_fb[c] = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({wr_valid, wr_start, wr_stop, frame_busy, frame_done, wr_value} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {wr_valid, wr_start, wr_stop, frame_busy, frame_done, wr_value});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle_quiet();
        new_run();
        repeat (300) @(negedge clk);
        checks++;
        if (cap_q.size() != 0 || frame_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet: %0d bytes issued, frame_busy=%b, expected 0 and 0",
                     cap_q.size(), frame_busy);
        end
    endtask

    task automatic test_basic_frame();
        bit ok;
        busy_len = 24;
        fb_write(0, 8'hA5);
        fb_write(15, 8'h3C);
        brightness = 3'd7;
        display_on = 1'b1;
        new_run();
        model_frame(1'b1, 3'd7);
        send_req();
        wait_frames(1, 3000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_timeout: frame_done count %0d expected 1", done_cnt); end
        repeat (60) @(negedge clk);
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt); end
        checks++;
        if (cap_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL basic_len: got %0d bytes expected %0d", cap_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (cap_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL basic_byte%0d: got %h expected %h", i, cap_q[i], exp_q[i]);
                end
            end
            checks++;
            if (cap_q[NCOL + 2] !== {2'b11, 8'h8F}) begin
                errors++;
                $display("FAIL basic_ctrl: got %h expected 38f", cap_q[NCOL + 2]);
            end
        end
    endtask

    task automatic test_random_frames();
        bit ok;
        logic [2:0] bri;
        bit on;
        for (int n = 0; n < 3; n++) begin
            busy_len = int'($urandom_range(1, 6));
            for (int c = 0; c < NCOL; c++) fb_write(c, 8'($urandom));
            bri = 3'($urandom);
            on  = 1'($urandom);
            brightness = bri;
            display_on = on;
            new_run();
            model_frame(on, bri);
            send_req();
            wait_frames(1, 2000, ok);
            repeat (busy_len + 10) @(negedge clk);
            checks++;
            if (!ok || cap_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rand%0d_len: got %0d bytes expected %0d", n, cap_q.size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    checks++;
                    if (cap_q[i] !== exp_q[i]) begin
                        errors++;
                        $display("FAIL rand%0d_byte%0d: got %h expected %h", n, i, cap_q[i], exp_q[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_display_latch();
        bit ok;
        busy_len   = 3;
        display_on = 1'b0;
        brightness = 3'd5;
        new_run();
        model_frame(1'b0, 3'd5);
        send_req();
        wait_bytes(5, 500, ok);
        display_on = 1'b1;
        brightness = 3'd2;
        wait_frames(1, 2000, ok);
        repeat (busy_len + 10) @(negedge clk);
        checks++;
        if (!ok || cap_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL latch_len: got %0d bytes expected %0d", cap_q.size(), exp_q.size());
        end else begin
            checks++;
            if (cap_q[NCOL + 2] !== {2'b11, 8'h80}) begin
                errors++;
                $display("FAIL latch_ctrl: got %h expected 380", cap_q[NCOL + 2]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int idle_snap;
        busy_len   = 4;
        display_on = 1'b1;
        brightness = 3'd3;
        new_run();
        model_frame(1'b1, 3'd3);
        model_frame(1'b1, 3'd3);
        send_req();
        @(negedge clk);
        idle_snap = idle_cnt;
        wait_bytes(3, 500, ok);
        send_req();
        repeat (5) @(negedge clk);
        send_req();
        repeat (7) @(negedge clk);
        send_req();
        wait_frames(2, 3000, ok);
        checks++;
        if (!ok || idle_cnt != idle_snap) begin
            errors++;
            $display("FAIL b2b_gap: done=%0d idle cycles between frames %0d expected 2 and 0",
                     done_cnt, idle_cnt - idle_snap);
        end
        repeat (1500) @(negedge clk);
        checks++;
        if (done_cnt != 2) begin errors++; $display("FAIL b2b_frames: got %0d expected 2", done_cnt); end
        checks++;
        if (cap_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_len: got %0d bytes expected %0d", cap_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (cap_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL b2b_byte%0d: got %h expected %h", i, cap_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_fb_collision();
        bit ok;
        logic [7:0] nv;
        busy_len = 6;
        nv = ~mdl_fb[3];
        for (int pass = 0; pass < 2; pass++) begin
            new_run();
            model_frame(display_on, brightness);
            send_req();
            if (pass == 0) begin
                wait_bytes(11, 500, ok);
                fb_write(3, nv);
            end
            wait_frames(1, 2000, ok);
            repeat (busy_len + 10) @(negedge clk);
            checks++;
            if (!ok || cap_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL coll%0d_len: got %0d bytes expected %0d", pass, cap_q.size(), exp_q.size());
            end else begin
                checks++;
                if (cap_q[5] !== exp_q[5]) begin
                    errors++;
                    $display("FAIL coll%0d_col3: got %h expected %h", pass, cap_q[5], exp_q[5]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        busy_len = 6;
        for (int c = 0; c < NCOL; c++) fb_write(c, 8'($urandom_range(1, 255)));
        new_run();
        send_req();
        wait_bytes(8, 500, ok);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (!ok || {wr_valid, frame_busy, frame_done} !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_abort: valid/busy/done=%b reached=%0d expected 000",
                     {wr_valid, frame_busy, frame_done}, ok);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < NCOL; c++) mdl_fb[c] = 8'h00;
        cap_q.delete();
        repeat (100) @(negedge clk);
        checks++;
        if (cap_q.size() != 0 || frame_busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_quiet: %0d bytes, frame_busy=%b, expected 0 and 0",
                     cap_q.size(), frame_busy);
        end
        new_run();
        model_frame(display_on, brightness);
        send_req();
        wait_frames(1, 2000, ok);
        repeat (busy_len + 10) @(negedge clk);
        checks++;
        if (!ok || cap_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rstmid_len: got %0d bytes expected %0d", cap_q.size(), exp_q.size());
        end else begin
            for (int i = 2; i < NCOL + 2; i++) begin
                checks++;
                if (cap_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rstmid_col%0d: got %h expected %h", i - 2, cap_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_auto_refresh();
        bit ok;
        int lat;
        busy_len = 2;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (frame_busy === 1'b1) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat != 10) begin errors++; $display("FAIL auto_first: frame start after %0d cycles expected 10", lat); end
        new_run();
        wait_frames(3, 3000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL auto_repeat: got %0d frames expected at least 3", done_cnt); end
    endtask

    initial begin
        test_reset();
`ifdef LEDARRAY_AUTO_REFRESH_EN
        test_auto_refresh();
`else
        test_idle_quiet();
        test_basic_frame();
        test_random_frames();
        test_display_latch();
        test_back_to_back();
        test_fb_collision();
        test_reset_mid_frame();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ledarray_frame_ctrl.md
LEDARRAY_FRAME_CTRL -- requirements
Module: ledarray_frame_ctrl

Interface
REQ-001 Parameters SHALL be: CLK_HZ, default 12_000_000, system clock rate; REFRESH_HZ, default 50, auto-refresh rate; NUM_COLS, default 16, frame columns (1..16).
REQ-002 Ports SHALL be, in order:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- fb_we  in  1  host frame-buffer write strobe.
- fb_addr  in  4  column index.
- fb_data  in  8  column pixel byte.
- brightness  in  3  display brightness level.
- display_on  in  1  panel enable.
- refresh_req  in  1  one-cycle frame-send request.
- wr_valid  out  1  one-cycle byte issue to the byte writer.
- wr_value  out  8  byte to send.
- wr_start  out  1  byte opens a bus transaction.
- wr_stop  out  1  byte closes a bus transaction.
- wr_busy  in  1  byte writer busy.
- frame_busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse when a frame completes.

Function
REQ-003 Frame buffer SHALL be NUM_COLS x 8 bits; fb_we writes fb_data to fb_addr on the same edge; fb_addr >= NUM_COLS SHALL be ignored.
REQ-004 Top FSM SHALL have these states: IDLE -> CMD_MODE -> ADDR -> DATA -> CTRL -> DONE -> IDLE.
REQ-005 CMD_MODE SHALL send 0x40 with wr_start=1 and wr_stop=1.
REQ-006 ADDR SHALL send 0xC0 with wr_start=1 and wr_stop=0.
REQ-007 DATA SHALL send columns 0..NUM_COLS-1 in order; only the last column has wr_stop=1; wr_start=0 throughout.
REQ-008 CTRL SHALL send {5'b10001, bri_latched} when the latched display_on=1, else 0x80; wr_start=1 and wr_stop=1.
REQ-009 Each byte SHALL use the sub-sequence ISSUE -> WAIT_HI -> WAIT_LO:
- ISSUE: only when wr_busy=0; assert wr_valid for exactly 1 cycle with wr_value, wr_start and wr_stop valid in that cycle.
- WAIT_HI: wait for wr_busy=1.
- WAIT_LO: wait for wr_busy=0, then advance.
REQ-010 wr_value, wr_start and wr_stop SHALL hold stable from ISSUE until WAIT_LO exits.
REQ-011 The column counter SHALL be 4 bits, clear on ADDR entry, and increment at each DATA byte completion; DATA exits when it reaches NUM_COLS-1 and that byte completes.
REQ-012 brightness and display_on SHALL be latched on the IDLE -> CMD_MODE transition and held for the whole frame.
REQ-013 Each data byte SHALL be read from the frame buffer at its ISSUE cycle; a host write to an already-sent column appears in the next frame.
REQ-014 A simultaneous fb_we and ISSUE read of the same column SHALL send the old value.
REQ-015 refresh_req in IDLE SHALL start a frame on the next cycle.
REQ-016 refresh_req while frame_busy=1 SHALL set a single pending flag; multiple requests coalesce into one, and DONE restarts a frame when the flag is set.
REQ-017 frame_busy SHALL be 1 in every state except IDLE; frame_done SHALL pulse for 1 cycle in DONE.

Reset
REQ-018 While rst_n=0:
- FSM in IDLE.
- Counters, pending flag and latches cleared.
- Frame buffer cleared to 0x00.
- wr_valid, wr_start, wr_stop, frame_busy and frame_done = 0; wr_value = 0x00.
REQ-019 Reset asserted mid-frame SHALL abort the frame immediately; after release, no frame starts until a request (or auto-refresh tick).

Configuration
REQ-020 Macro LEDARRAY_AUTO_REFRESH_EN defined:
- A counter of width clog2(CLK_HZ/REFRESH_HZ) ticks every CLK_HZ/REFRESH_HZ cycles.
- A tick is treated exactly as refresh_req, including pending-flag coalescing.
- The counter runs from reset release.
Macro undefined: no counter logic; frames start only on refresh_req.

Verification
REQ-021 Bench SHALL cover these scenarios:
- Reset, write col0=0xA5 and col15=0x3C, refresh_req, with a writer model holding busy 24 cycles per byte -> byte stream 0x40(s,p), 0xC0(s), 0xA5, 0x00 x14, 0x3C(p), 0x8F with brightness=7 and display_on=1; one frame_done pulse.
- display_on=0 latched at start, toggled to 1 mid-frame -> last byte 0x80.
- Three refresh_req pulses during one frame -> exactly two frames total, back-to-back.
- fb write to col3 while col8 is in flight -> current frame sends the old col3; next frame sends the new value.
- rst_n low during DATA col5 -> wr_valid=0, frame_busy=0 and buffer=0x00 on release; no further wr_valid until a refresh.
- With LEDARRAY_AUTO_REFRESH_EN and CLK_HZ=1000, REFRESH_HZ=100 -> a frame starts every 10 cycles when idle; without the macro there is no activity.
